// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared types and constants for the fetch/LSU memory port arbiter.
//   - CNT_W        : width of the starvation counter (holds limits up to 15)
//   - arb_state_e  : arbiter FSM states
//   - sat_inc()    : saturating increment used by the starvation counter
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ARB_ST_IDLE   = 2'd0,
        ARB_ST_BUSY_F = 2'd1,
        ARB_ST_BUSY_L = 2'd2
    } arb_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                                 input logic [CNT_W-1:0] limit);
        return (val >= limit) ? limit : val + CNT_W'(1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//   Bundles the fetch request port, the LSU request port and the memory
//   command/response port seen by the arbiter.
//   Modports:
//     slave  - the arbiter: receives fetch/LSU requests and memory responses,
//              drives grants, read data and the memory command.
//     master - the environment: fetch stage, LSU and memory model.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // fetch port
    logic            if_req;
    logic [AW-1:0]   if_addr;
    logic            if_flush;
    logic            if_gnt;
    logic            if_rvalid;
    logic [DW-1:0]   if_rdata;
    // load/store port
    logic            ls_req;
    logic            ls_we;
    logic [AW-1:0]   ls_addr;
    logic [DW-1:0]   ls_wdata;
    logic [DW/8-1:0] ls_wstrb;
    logic            ls_gnt;
    logic            ls_rvalid;
    logic [DW-1:0]   ls_rdata;
    // memory port
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_wstrb;
    logic            mem_ready;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        input  mem_ready, mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output if_req, if_addr, if_flush,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb,
        output mem_ready, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
//   Combinational winner select for an idle arbiter plus the starvation
//   counter that stops a continuous LSU stream from locking out fetch.
//   Ports:
//     clk, reset   : clock, asynchronous active-high reset
//     i_idle       : arbiter is idle and may grant this cycle
//     i_if_req     : fetch request
//     i_if_flush   : fetch flush (a flushed fetch may not be granted)
//     i_ls_req     : LSU request
//     o_pick_ls    : LSU wins this cycle
//     o_pick_if    : fetch wins this cycle
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic i_idle,
    input  logic i_if_req,
    input  logic i_if_flush,
    input  logic i_ls_req,
    output logic o_pick_ls,
    output logic o_pick_if
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;
    logic             w_pick_ls;
    logic             w_pick_if;

    // LSU keeps priority until fetch has watched LIMIT LSU grants go by.
    assign w_pick_ls = i_idle && i_ls_req && ((r_cnt < LIMIT) || !i_if_req);
    assign w_pick_if = i_idle && !w_pick_ls && i_if_req && !i_if_flush;

    // NOTE: sequential state is written with non-blocking (<=) so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_if_req || w_pick_if) begin
            r_cnt <= '0;
        end else if (w_pick_ls && !i_if_flush) begin
            r_cnt <= sat_inc(r_cnt, LIMIT);
        end
    end

    assign o_pick_ls = w_pick_ls;
    assign o_pick_if = w_pick_if;

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-port memory between the fetch stage (read-only) and the
//   load/store unit (read/write). One transaction outstanding at a time; LSU
//   has priority with a starvation guard for fetch. A flush cancels delivery
//   of an in-flight fetch without aborting the memory cycle. All outputs are
//   registered.
//   Ports:
//     clk    : clock, all state on rising edge
//     reset  : asynchronous active-high reset
//     bus    : fetch, LSU and memory ports (slave modport of
//              mem_port_arbiter_if)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
)(
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_e      r_state,     w_state_nxt;
    logic            r_if_gnt,    w_if_gnt_nxt;
    logic            r_ls_gnt,    w_ls_gnt_nxt;
    logic            r_if_rvalid, w_if_rvalid_nxt;
    logic            r_ls_rvalid, w_ls_rvalid_nxt;
    logic [DW-1:0]   r_if_rdata,  w_if_rdata_nxt;
    logic [DW-1:0]   r_ls_rdata,  w_ls_rdata_nxt;
    logic            r_mem_req,   w_mem_req_nxt;
    logic            r_mem_we,    w_mem_we_nxt;
    logic [AW-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DW-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [DW/8-1:0] r_mem_wstrb, w_mem_wstrb_nxt;
    logic            r_drop,      w_drop_nxt;

    logic w_idle;
    logic w_pick_ls;
    logic w_pick_if;

    assign w_idle = (r_state == ARB_ST_IDLE);

    mem_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .clk        (clk),
        .reset      (reset),
        .i_idle     (w_idle),
        .i_if_req   (bus.if_req),
        .i_if_flush (bus.if_flush),
        .i_ls_req   (bus.ls_req),
        .o_pick_ls  (w_pick_ls),
        .o_pick_if  (w_pick_if)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_if_gnt_nxt    = 1'b0;
        w_ls_gnt_nxt    = 1'b0;
        w_if_rvalid_nxt = 1'b0;
        w_ls_rvalid_nxt = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_ls_rdata_nxt  = r_ls_rdata;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_wstrb_nxt = r_mem_wstrb;
        w_drop_nxt      = r_drop;

        unique case (r_state)
            ARB_ST_IDLE: begin
                w_drop_nxt = 1'b0;
                if (w_pick_ls) begin
                    w_state_nxt     = ARB_ST_BUSY_L;
                    w_ls_gnt_nxt    = 1'b1;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.ls_we;
                    w_mem_addr_nxt  = bus.ls_addr;
                    w_mem_wdata_nxt = bus.ls_wdata;
                    w_mem_wstrb_nxt = bus.ls_wstrb;
                end else if (w_pick_if) begin
                    w_state_nxt     = ARB_ST_BUSY_F;
                    w_if_gnt_nxt    = 1'b1;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_addr_nxt  = bus.if_addr;
                    w_mem_wdata_nxt = '0;
                    w_mem_wstrb_nxt = '0;
                end
            end

            ARB_ST_BUSY_F: begin
                // A flush seen in the completion cycle still drops the data.
                if (bus.mem_ready) begin
                    w_state_nxt   = ARB_ST_IDLE;
                    w_mem_req_nxt = 1'b0;
                    w_drop_nxt    = 1'b0;
                    if (!(r_drop || bus.if_flush)) begin
                        w_if_rvalid_nxt = 1'b1;
                        w_if_rdata_nxt  = bus.mem_rdata;
                    end
                end else begin
                    w_drop_nxt = r_drop || bus.if_flush;
                end
            end

            ARB_ST_BUSY_L: begin
                if (bus.mem_ready) begin
                    w_state_nxt     = ARB_ST_IDLE;
                    w_mem_req_nxt   = 1'b0;
                    w_ls_rvalid_nxt = 1'b1;
                    // Writes only acknowledge; ls_rdata keeps the last read.
                    if (!r_mem_we) begin
                        w_ls_rdata_nxt = bus.mem_rdata;
                    end
                end
            end

            default: begin
                w_state_nxt   = ARB_ST_IDLE;
                w_mem_req_nxt = 1'b0;
                w_drop_nxt    = 1'b0;
            end
        endcase
    end

    // NOTE: the command/data registers are reset as well: they are a few
    // port-facing flops, not a RAM, and every output must read 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_ST_IDLE;
            r_if_gnt    <= 1'b0;
            r_ls_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_drop      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_if_gnt    <= w_if_gnt_nxt;
            r_ls_gnt    <= w_ls_gnt_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_ls_rvalid <= w_ls_rvalid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_ls_rdata  <= w_ls_rdata_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_wstrb <= w_mem_wstrb_nxt;
            r_drop      <= w_drop_nxt;
        end
    end

    assign bus.if_gnt    = r_if_gnt;
    assign bus.if_rvalid = r_if_rvalid;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.ls_gnt    = r_ls_gnt;
    assign bus.ls_rvalid = r_ls_rvalid;
    assign bus.ls_rdata  = r_ls_rdata;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed scenarios followed by a randomized phase. A transaction-level
//   reference (busy flag, owner, drop flag, starvation streak, word memory)
//   predicts grants, completions and read data every cycle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(
        .AW           (AW),
        .DW           (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model and responder state
    logic [31:0] mem_model [logic [31:0]];
    int          mem_lat;
    int          lat_cnt;
    logic        prev_mem_req;
    logic        spurious_en;

    // reference model state
    logic        m_busy, m_owner_ls, m_we, m_drop;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    int          m_streak;
    logic [31:0] m_if_rdata, m_ls_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return 32'h0;
    endfunction

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = mem_rd(a);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        end
        mem_model[a] = w;
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner_ls = 0; m_we = 0; m_drop = 0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0; m_streak = 0;
        m_if_rdata = '0; m_ls_rdata = '0;
        prev_mem_req = 0; lat_cnt = 0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_if_gnt"},    bus.if_gnt,    0);
        check({tag, "_if_rvalid"}, bus.if_rvalid, 0);
        check({tag, "_if_rdata"},  bus.if_rdata,  0);
        check({tag, "_ls_gnt"},    bus.ls_gnt,    0);
        check({tag, "_ls_rvalid"}, bus.ls_rvalid, 0);
        check({tag, "_ls_rdata"},  bus.ls_rdata,  0);
        check({tag, "_mem_req"},   bus.mem_req,   0);
        check({tag, "_mem_we"},    bus.mem_we,    0);
        check({tag, "_mem_addr"},  bus.mem_addr,  0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_mem_wstrb"}, bus.mem_wstrb, 0);
    endtask

    // One clock: answer the memory, advance past the edge, predict and compare.
    task automatic cycle();
        logic        p_if_req, p_if_flush, p_ls_req, p_ls_we, p_ready;
        logic [31:0] p_if_addr, p_ls_addr, p_ls_wdata, p_rdata;
        logic [3:0]  p_ls_wstrb;
        logic        e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv;

        p_if_req   = bus.if_req;   p_if_flush = bus.if_flush; p_if_addr = bus.if_addr;
        p_ls_req   = bus.ls_req;   p_ls_we    = bus.ls_we;    p_ls_addr = bus.ls_addr;
        p_ls_wdata = bus.ls_wdata; p_ls_wstrb = bus.ls_wstrb;

        if (bus.mem_req && !prev_mem_req) lat_cnt = mem_lat;
        if (bus.mem_req) bus.mem_ready = (lat_cnt == 0);
        else             bus.mem_ready = spurious_en && (($urandom & 1) != 0);
        if (bus.mem_req && bus.mem_ready && !bus.mem_we) bus.mem_rdata = mem_rd(bus.mem_addr);
        else                                             bus.mem_rdata = $urandom;
        if (bus.mem_req && bus.mem_ready && bus.mem_we)
            mem_wr(bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
        p_ready = bus.mem_ready;
        p_rdata = bus.mem_rdata;
        prev_mem_req = bus.mem_req;
        if (bus.mem_req && lat_cnt > 0) lat_cnt--;

        @(posedge clk);
        #1;

        e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0;
        if (!m_busy) begin
            e_ls_gnt = p_ls_req && ((m_streak < LIM) || !p_if_req);
            e_if_gnt = !e_ls_gnt && p_if_req && !p_if_flush;
            if (e_ls_gnt) begin
                m_busy = 1; m_owner_ls = 1; m_we = p_ls_we; m_addr = p_ls_addr;
                m_wdata = p_ls_wdata; m_wstrb = p_ls_wstrb; m_drop = 0;
            end else if (e_if_gnt) begin
                m_busy = 1; m_owner_ls = 0; m_we = 0; m_addr = p_if_addr; m_drop = 0;
            end
        end else begin
            if (!m_owner_ls && p_if_flush) m_drop = 1;
            if (p_ready) begin
                if (m_owner_ls) begin
                    e_ls_rv = 1;
                    if (!m_we) m_ls_rdata = p_rdata;
                end else if (!m_drop) begin
                    e_if_rv = 1;
                    m_if_rdata = p_rdata;
                end
                m_busy = 0;
                m_drop = 0;
            end
        end
        if (!p_if_req || e_if_gnt)                  m_streak = 0;
        else if (e_ls_gnt && !p_if_flush && m_streak < LIM) m_streak++;

        check("if_gnt",    bus.if_gnt,    e_if_gnt);
        check("ls_gnt",    bus.ls_gnt,    e_ls_gnt);
        check("if_rvalid", bus.if_rvalid, e_if_rv);
        check("ls_rvalid", bus.ls_rvalid, e_ls_rv);
        check("if_rdata",  bus.if_rdata,  m_if_rdata);
        check("ls_rdata",  bus.ls_rdata,  m_ls_rdata);
        check("mem_req",   bus.mem_req,   m_busy);
        if (m_busy) begin
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_we",   bus.mem_we,   m_we);
            if (m_owner_ls && m_we) begin
                check("mem_wdata", bus.mem_wdata, m_wdata);
                check("mem_wstrb", bus.mem_wstrb, m_wstrb);
            end
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return bus.if_gnt;
            1:       return bus.ls_gnt;
            2:       return bus.if_rvalid;
            default: return bus.ls_rvalid;
        endcase
    endfunction

    task automatic wait_for(input int which, input int budget, input string tag);
        logic seen;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            cycle();
            seen = sig(which);
        end
        check(tag, seen, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        saw;
        int          n_ls;
        logic        got_if;
        logic [31:0] rd_before;

        reset = 1;
        bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
        bus.ls_req = 0; bus.ls_we = 0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_wstrb = '0;
        bus.mem_ready = 0; bus.mem_rdata = '0;
        spurious_en = 0; mem_lat = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 0;

        // 1. fetch only, memory ready one cycle after mem_req
        mem_model[32'h100] = 32'hA5A5_0100;
        mem_lat = 1;
        bus.if_req = 1; bus.if_addr = 32'h100;
        cycle();
        check("t1_gnt", bus.if_gnt, 1);
        check("t1_addr", bus.mem_addr, 32'h100);
        bus.if_req = 0;
        cycle();
        check("t1_req_hold", bus.mem_req, 1);
        cycle();
        check("t1_rvalid", bus.if_rvalid, 1);
        check("t1_rdata", bus.if_rdata, 32'hA5A5_0100);
        cycle();

        // 2. simultaneous requests: LSU first, fetch right after ls_rvalid
        mem_model[32'h200] = 32'h2222_0200;
        mem_model[32'h300] = 32'h3333_0300;
        mem_lat = 0;
        bus.if_req = 1; bus.if_addr = 32'h300;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h200;
        cycle();
        check("t2_ls_first", bus.ls_gnt, 1);
        check("t2_if_wait", bus.if_gnt, 0);
        bus.ls_req = 0;
        cycle();
        check("t2_ls_rvalid", bus.ls_rvalid, 1);
        check("t2_ls_rdata", bus.ls_rdata, 32'h2222_0200);
        cycle();
        check("t2_if_gnt_next", bus.if_gnt, 1);
        bus.if_req = 0;
        wait_for(2, 8, "t2_if_rvalid_seen");
        check("t2_if_rdata", bus.if_rdata, 32'h3333_0300);
        cycle();

        // 3. starvation guard: four LSU grants, then fetch
        bus.if_req = 1; bus.if_addr = 32'h600;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h0;
        n_ls = 0; got_if = 0;
        for (int i = 0; i < 40 && !got_if; i++) begin
            cycle();
            if (bus.ls_gnt) begin
                n_ls++;
                bus.ls_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (bus.if_gnt) begin
                got_if = 1;
                bus.if_req = 0;
                bus.ls_req = 0;
            end
        end
        check("t3_if_granted", got_if, 1);
        check("t3_ls_grants", n_ls, LIM);
        wait_for(2, 8, "t3_if_rvalid_seen");
        bus.if_req = 1; bus.ls_req = 1;
        cycle();
        check("t3_cnt_cleared_ls_wins", bus.ls_gnt, 1);
        bus.ls_req = 0;
        wait_for(0, 8, "t3_if_gnt_seen");
        bus.if_req = 0;
        repeat (3) cycle();

        // 4. flush during a 3-cycle fetch: cycle completes, data dropped
        mem_model[32'h400] = 32'h4444_0400;
        mem_model[32'h404] = 32'h4444_0404;
        mem_lat = 3;
        bus.if_req = 1; bus.if_addr = 32'h400;
        cycle();
        check("t4_gnt", bus.if_gnt, 1);
        bus.if_req = 0; bus.if_flush = 1;
        cycle();
        bus.if_flush = 0;
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            saw = saw | bus.if_rvalid;
        end
        check("t4_no_rvalid", saw, 0);
        check("t4_mem_idle", bus.mem_req, 0);
        bus.if_req = 1; bus.if_addr = 32'h404;
        wait_for(0, 4, "t4_next_gnt");
        bus.if_req = 0;
        wait_for(2, 10, "t4_next_rvalid");
        check("t4_next_rdata", bus.if_rdata, 32'h4444_0404);

        // 5. LSU partial write, then read back
        mem_lat = 1;
        rd_before = m_ls_rdata;
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_addr = 32'h40;
        bus.ls_wdata = 32'hDEAD_BEEF; bus.ls_wstrb = 4'b0011;
        cycle();
        check("t5_gnt", bus.ls_gnt, 1);
        check("t5_we", bus.mem_we, 1);
        check("t5_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
        check("t5_wstrb", bus.mem_wstrb, 4'b0011);
        bus.ls_req = 0;
        wait_for(3, 8, "t5_write_ack");
        check("t5_rdata_held", bus.ls_rdata, rd_before);
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h40;
        wait_for(1, 4, "t5_rd_gnt");
        bus.ls_req = 0;
        wait_for(3, 8, "t5_rd_rvalid");
        check("t5_readback", bus.ls_rdata, 32'h0000_BEEF);

        // 6. asynchronous reset in the middle of a transaction
        mem_lat = 5;
        bus.if_req = 1; bus.if_addr = 32'h500;
        wait_for(0, 4, "t6_gnt");
        bus.if_req = 0;
        cycle();
        check("t6_busy", bus.mem_req, 1);
        #2;
        reset = 1;
        #1;
        check_zero("t6_async");
        @(posedge clk);
        #1;
        check_zero("t6_hold");
        reset = 0;
        model_reset();
        repeat (4) cycle();
        mem_model[32'h504] = 32'h5555_0504;
        mem_lat = 1;
        bus.if_req = 1; bus.if_addr = 32'h504;
        cycle();
        check("t6_after_gnt", bus.if_gnt, 1);
        bus.if_req = 0;
        wait_for(2, 6, "t6_after_rvalid");
        check("t6_after_rdata", bus.if_rdata, 32'h5555_0504);

        // randomized traffic with flushes, early withdrawals and stray mem_ready
        spurious_en = 1;
        for (int i = 0; i < 400; i++) begin
            mem_lat = $urandom_range(0, 3);
            if (!bus.if_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.if_req  = 1;
                    bus.if_addr = 32'($urandom_range(0, 15)) << 2;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.if_req = 0;
            end
            if (!bus.ls_req) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.ls_req   = 1;
                    bus.ls_we    = ($urandom & 1) != 0;
                    bus.ls_addr  = 32'($urandom_range(0, 15)) << 2;
                    bus.ls_wdata = $urandom;
                    bus.ls_wstrb = 4'($urandom_range(0, 15));
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.ls_req = 0;
            end
            bus.if_flush = ($urandom_range(0, 7) == 0);
            cycle();
            if (bus.if_gnt) bus.if_req = 0;
            if (bus.ls_gnt) bus.ls_req = 0;
        end
        bus.if_req = 0; bus.ls_req = 0; bus.if_flush = 0; spurious_en = 0;
        repeat (8) cycle();
        check("drain_idle", bus.mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
